// File: rtl/vreg_streamer_if.sv
// Lane stream from vreg_streamer to its consumer, carrying one N-bit element per transfer.
// A lane moves on a rising edge where lane_valid && lane_ready; while lane_valid is high and lane_ready low, the master holds data/idx/last stable.
interface vreg_streamer_if #(
  parameter int N = 18,
  parameter int V = 3
);
  localparam int IW = (V > 1) ? $clog2(V) : 1;

  logic [N-1:0]  lane_data;
  logic          lane_valid;
  logic          lane_ready;
  logic [IW-1:0] lane_idx;
  logic          lane_last;

  modport master (
    output lane_data,
    output lane_valid,
    output lane_idx,
    output lane_last,
    input  lane_ready
  );

  modport slave (
    input  lane_data,
    input  lane_valid,
    input  lane_idx,
    input  lane_last,
    output lane_ready
  );
endinterface

// File: rtl/vreg_streamer.sv
// Streams a run of vector registers out of a register file one lane at a time.
// Register 15 holds the PC, so transfers are clipped at register 14 and flagged with err.
module vreg_streamer #(
  parameter int N = 18,
  parameter int V = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [3:0]     base_addr,
  input  logic [3:0]     count,
  output logic [3:0]     ra,
  input  logic [V*N-1:0] rd,
  vreg_streamer_if.master lane,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic [1:0]     dbg_state
);
  localparam int IW = (V > 1) ? $clog2(V) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_STREAM = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [3:0]     reg_idx_q;
  logic [3:0]     last_q;
  logic           trunc_q;
  logic [IW-1:0]  lane_cnt_q;
  logic [V*N-1:0] buf_q;

  logic [4:0] end_sum;
  logic       lane_end;
  logic       reg_end;
  logic       xfer;

  // Index of the final requested register; only meaningful when count != 0.
  assign end_sum  = {1'b0, base_addr} + {1'b0, count} - 5'd1;
  assign lane_end = (lane_cnt_q == IW'(V - 1));
  assign reg_end  = (reg_idx_q == last_q);
  assign xfer     = (state_q == S_STREAM) && lane.lane_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (count == 4'd0 || base_addr == 4'hF) state_d = S_DONE;
          else                                    state_d = S_LOAD;
        end
      end
      S_LOAD:   state_d = S_STREAM;
      S_STREAM: begin
        if (xfer && lane_end) state_d = reg_end ? S_DONE : S_LOAD;
      end
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reg_idx_q  <= '0;
      last_q     <= '0;
      trunc_q    <= 1'b0;
      lane_cnt_q <= '0;
      buf_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            reg_idx_q <= base_addr;
            trunc_q   <= (count != 4'd0) && (end_sum > 5'd14);
            last_q    <= (end_sum > 5'd14) ? 4'd14 : end_sum[3:0];
          end
        end
        S_LOAD: begin
          buf_q      <= rd;
          lane_cnt_q <= '0;
        end
        S_STREAM: begin
          if (xfer) begin
            if (lane_end) begin
              lane_cnt_q <= '0;
              if (!reg_end) reg_idx_q <= reg_idx_q + 4'd1;
            end else begin
              lane_cnt_q <= lane_cnt_q + IW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ra              = 4'd0;
    busy            = (state_q != S_IDLE);
    done            = (state_q == S_DONE);
    err             = (state_q == S_DONE) && trunc_q;
    lane.lane_valid = 1'b0;
    lane.lane_idx   = '0;
    lane.lane_last  = 1'b0;
    lane.lane_data  = '0;
    dbg_state       = state_q;
    if (state_q == S_LOAD || state_q == S_STREAM) ra = reg_idx_q;
    if (state_q == S_STREAM) begin
      lane.lane_valid = 1'b1;
      lane.lane_idx   = lane_cnt_q;
      lane.lane_last  = lane_end && reg_end;
      for (int k = 0; k < V; k++) begin
        if (lane_cnt_q == IW'(k)) lane.lane_data = buf_q[k*N +: N];
      end
    end
  end
endmodule

// File: tb/tb_vreg_streamer.sv
// Bench for vreg_streamer: a register file model, a lane scoreboard built from base/count, and directed plus random transfers.
module tb_vreg_streamer;
  localparam int N  = 18;
  localparam int V  = 3;
  localparam int IW = (V > 1) ? $clog2(V) : 1;
  localparam int W  = 4 + 1 + IW + N;

  logic           clk;
  logic           reset;
  logic           start;
  logic [3:0]     base_addr;
  logic [3:0]     count;
  logic [3:0]     ra;
  logic [V*N-1:0] rd;
  logic           busy, done, err;
  logic [1:0]     dbg_state;

  logic [V*N-1:0] rf [0:15];
  logic [W-1:0]   exp_q[$];
  int errors = 0;
  int checks = 0;

  vreg_streamer_if #(.N(N), .V(V)) lif ();

  vreg_streamer #(.N(N), .V(V)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .count(count),
    .ra(ra), .rd(rd), .lane(lif.master), .busy(busy), .done(done), .err(err),
    .dbg_state(dbg_state)
  );

  assign rd = rf[ra];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Drives one transfer and scores every displayed lane against the model.
  // mode 0: ready always 1, 1: random ready + ignored start pulses, 2: stall lane stall_lane for stall_len cycles.
  task automatic run_transfer(input logic [3:0] b, input logic [3:0] c, input int mode,
                              input int stall_lane, input int stall_len);
    int nreg, last_r, cyc, scnt;
    bit exp_err, fin, stalled, rdy;
    logic [W-1:0] held, got;
    exp_q.delete();
    nreg    = 0;
    last_r  = (int'(b) + int'(c) - 1 > 14) ? 14 : int'(b) + int'(c) - 1;
    exp_err = (c != 0) && (int'(b) + int'(c) - 1 > 14);
    if (c != 0) begin
      for (int r = int'(b); r <= last_r; r++) begin
        nreg++;
        for (int k = 0; k < V; k++)
          exp_q.push_back({4'(r), (r == last_r && k == V - 1), IW'(k), rf[r][k*N +: N]});
      end
    end
    start = 1'b1; base_addr = b; count = c;
    @(posedge clk); #1;
    start = 1'b0; base_addr = 4'($urandom); count = 4'($urandom);
    cyc = 0; fin = 0; stalled = 0; scnt = 0; held = '0;
    while (!fin && cyc < 200) begin
      cyc++;
      checks++;
      if (ra === 4'hF) begin errors++; $display("FAIL ra_not_15: got ra=%0d required not 15", ra); end
      if (cyc == 1 && nreg > 0) begin
        checks++;
        if (ra !== b || lif.lane_valid !== 1'b0 || busy !== 1'b1) begin
          errors++; $display("FAIL load_cycle: got ra=%0d valid=%0b busy=%0b required ra=%0d valid=0 busy=1", ra, lif.lane_valid, busy, b);
        end
      end
      got = {ra, lif.lane_last, lif.lane_idx, lif.lane_data};
      if (stalled) begin
        checks++;
        if (lif.lane_valid !== 1'b1 || got !== held) begin
          errors++; $display("FAIL hold_stable: got valid=%0b lane=%0h required valid=1 lane=%0h", lif.lane_valid, got, held);
        end
      end
      if (done === 1'b1) begin
        fin = 1;
        checks++;
        if (err !== exp_err) begin errors++; $display("FAIL done_err: got err=%0b required %0b", err, exp_err); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL lanes_missing: got %0d lanes left required 0", exp_q.size()); end
        if (mode == 0) begin
          checks++;
          if (cyc != 1 + nreg * (V + 1)) begin
            errors++; $display("FAIL done_latency: got cycle %0d required %0d", cyc, 1 + nreg * (V + 1));
          end
        end
        start = 1'b1;
      end else begin
        checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
          errors++; $display("FAIL busy_no_err: got busy=%0b err=%0b required busy=1 err=0", busy, err);
        end
        if (mode == 0) rdy = 1;
        else if (mode == 1) rdy = ($urandom_range(0, 2) != 0);
        else begin
          rdy = 1;
          if (lif.lane_valid === 1'b1 && int'(lif.lane_idx) == stall_lane && scnt < stall_len) begin
            rdy = 0; scnt++;
          end
        end
        lif.lane_ready = rdy;
        if (lif.lane_valid === 1'b1) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++; $display("FAIL extra_lane: got lane=%0h required no lane", got);
          end else if (got !== exp_q[0]) begin
            errors++; $display("FAIL lane_content: got {ra,last,idx,data}=%0h required %0h", got, exp_q[0]);
          end
          if (rdy && exp_q.size() != 0) void'(exp_q.pop_front());
        end
        stalled = (lif.lane_valid === 1'b1) && !rdy;
        held    = got;
        if (mode == 1) start = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
    end
    if (!fin) begin
      checks++; errors++;
      $display("FAIL done_timeout: got no done in %0d cycles required done", cyc);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL back_to_idle: got busy=%0b done=%0b err=%0b required 0 0 0", busy, done, err);
    end
    start = 1'b0;
    lif.lane_ready = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b0; base_addr = 4'd0; count = 4'd0; lif.lane_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({ra, lif.lane_data, lif.lane_valid, lif.lane_idx, lif.lane_last, busy, done, err} !== '0) begin
      errors++; $display("FAIL reset_outputs: got ra=%0d data=%0h valid=%0b idx=%0d last=%0b busy=%0b done=%0b err=%0b required all 0",
                         ra, lif.lane_data, lif.lane_valid, lif.lane_idx, lif.lane_last, busy, done, err);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset: got busy=%0b required 0", busy); end
  endtask

  task automatic test_single;      run_transfer(4'd2, 4'd1, 0, 0, 0); endtask
  task automatic test_two_regs;    run_transfer(4'd4, 4'd2, 0, 0, 0); endtask
  task automatic test_backpressure; run_transfer(4'd2, 4'd1, 2, 1, 4); endtask
  task automatic test_truncate;    run_transfer(4'd13, 4'd4, 0, 0, 0); endtask
  task automatic test_base15;      run_transfer(4'd15, 4'd3, 0, 0, 0); endtask
  task automatic test_zero_count;  run_transfer(4'd6, 4'd0, 0, 0, 0); endtask

  task automatic test_back_to_back;
    run_transfer(4'd0, 4'd3, 0, 0, 0);
    run_transfer(4'd11, 4'd4, 0, 0, 0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 10; i++)
      run_transfer(4'($urandom_range(0, 15)), 4'($urandom_range(0, 6)), 1, 0, 0);
    for (int i = 0; i < 4; i++)
      run_transfer(4'($urandom_range(0, 12)), 4'($urandom_range(1, 3)), 2,
                   $urandom_range(0, V - 1), $urandom_range(1, 5));
  endtask

  task automatic test_reset_mid;
    int n;
    start = 1'b1; base_addr = 4'd4; count = 4'd2; lif.lane_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!(lif.lane_valid === 1'b1 && lif.lane_idx === IW'(1)) && n < 10) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (n >= 10) begin errors++; $display("FAIL reach_lane1: got no lane 1 in 10 cycles required lane 1"); end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({ra, lif.lane_data, lif.lane_valid, lif.lane_idx, lif.lane_last, busy, done, err} !== '0) begin
      errors++; $display("FAIL async_reset: got ra=%0d data=%0h valid=%0b idx=%0d busy=%0b done=%0b err=%0b required all 0",
                         ra, lif.lane_data, lif.lane_valid, lif.lane_idx, busy, done, err);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || err !== 1'b0) begin
        errors++; $display("FAIL abort_no_done: got done=%0b err=%0b required 0 0", done, err);
      end
    end
    reset = 1'b1;
    @(posedge clk); #1;
    run_transfer(4'd4, 4'd2, 0, 0, 0);
  endtask

  initial begin
    logic [63:0] t;
    for (int i = 0; i < 16; i++) begin
      t = {$urandom(), $urandom()};
      rf[i] = t[V*N-1:0];
    end
    rf[2] = {18'd3, 18'd2, 18'd1};
    test_reset;
    test_single;
    test_two_regs;
    test_backpressure;
    test_truncate;
    test_base15;
    test_zero_count;
    test_back_to_back;
    test_random;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vreg_streamer.md
VREG_STREAMER -- requirements
Module: vreg_streamer

Interface
REQ-001 The module SHALL have parameter N, default 18, lane data width in bits.
REQ-002 The module SHALL have parameter V, default 3, lanes per vector register.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset.
REQ-005 Port start  input  1  command strobe, sampled only in IDLE.
REQ-006 Port base_addr  input  4  first vector register index of the transfer.
REQ-007 Port count  input  4  number of vector registers to stream.
REQ-008 Port ra  output  4  read address to vector register file.
REQ-009 Port rd  input  V*N  combinational vector read data from the register file; lane k = bits [k*N+N-1 : k*N].
REQ-010 Port lane_data  output  N  current lane element.
REQ-011 Port lane_valid  output  1  lane_data valid.
REQ-012 Port lane_ready  input  1  downstream accepts lane.
REQ-013 Port lane_idx  output  $clog2(V)  lane number of lane_data.
REQ-014 Port lane_last  output  1  high with the final lane of the final register.
REQ-015 Port busy  output  1  high in any state other than IDLE.
REQ-016 Port done  output  1  one-cycle completion pulse.
REQ-017 Port err  output  1  one-cycle pulse coincident with done when the transfer was truncated.

Function
REQ-018 The FSM SHALL have states IDLE, LOAD, STREAM, DONE.
REQ-019 IDLE: start=1 SHALL latch base_addr and count, then go to LOAD; start=0 SHALL hold IDLE.
REQ-020 start SHALL be ignored in every state except IDLE.
REQ-021 count=0 SHALL go IDLE->DONE directly, with no lane_valid, done=1, err=0.
REQ-022 LOAD: ra SHALL equal the current register index; at the clock edge rd SHALL be captured into an internal V*N buffer, lane counter SHALL be 0, next state STREAM.
REQ-023 ra SHALL be 0 in IDLE and DONE and SHALL hold the current register index in STREAM.
REQ-024 STREAM: lane_valid=1, lane_data = buffered lane lane_idx, lane_idx = lane counter.
REQ-025 A lane transfer SHALL occur on a rising edge with lane_valid=1 and lane_ready=1; only then SHALL the lane counter advance.
REQ-026 While lane_valid=1 and lane_ready=0, lane_data, lane_idx, lane_last SHALL remain stable.
REQ-027 On a transfer of lane V-1 with registers remaining, the FSM SHALL increment the register index and go to LOAD (exactly one bubble cycle, lane_valid=0).
REQ-028 On a transfer of lane V-1 of the last register, the FSM SHALL go to DONE.
REQ-029 lane_last SHALL be 1 only when lane_valid=1, lane_idx=V-1 and the register is the final one.
REQ-030 The register index SHALL never reach 15 (register 15 returns the PC, not vector data): if base_addr+count-1 > 14, the transfer SHALL end after register 14 and err SHALL pulse with done.
REQ-031 base_addr=15 SHALL stream no lanes and SHALL go to DONE with err=1.
REQ-032 DONE SHALL last exactly one cycle with done=1, then return to IDLE; start during DONE SHALL be ignored.
REQ-033 Latency: start at edge t -> LOAD in cycle t+1 -> lane 0 valid in cycle t+2; with lane_ready held 1, one register takes V+1 cycles and done asserts V cycles after the final register's LOAD cycle completes.

Reset
REQ-034 reset=0 SHALL immediately force IDLE, with outputs ra=0, lane_data=0, lane_valid=0, lane_idx=0, lane_last=0, busy=0, done=0, err=0, and the lane buffer cleared.
REQ-035 Reset asserted mid-transfer SHALL abort with no done or err pulse, and after release the module SHALL accept a new start.

Verification
REQ-036 V=3, N=18, reg2 = {lane2=3, lane1=2, lane0=1}; start with base=2, count=1, ready=1 -> ra=2 in cycle t+1; lanes 1,2,3 in t+2..t+4; lane_last in t+4; done in t+5.
REQ-037 base=4, count=2, ready=1 -> ra=4, 3 lanes, one bubble, ra=5, 3 lanes, lane_last on the sixth lane, done=1, err=0.
REQ-038 Same as REQ-036 but ready=0 for 4 cycles during lane1 -> lane_data=2 and lane_idx=1 held stable; no lane lost or duplicated.
REQ-039 base=13, count=4 -> only registers 13 and 14 streamed (6 lanes); ra never 15; done=1 and err=1 together.
REQ-040 count=0 -> done the cycle after start, lane_valid never 1; a second start while busy is ignored.
REQ-041 reset=0 asserted during lane1 of a 2-register transfer -> all outputs 0 asynchronously; no done; a new start after release streams correctly.
